prbs6_checker: RTL and testbench
================================

// Module: prbs6_checker
// PURPOSE
//  Receive-side partner of the 6-bit PRBS generator (P(x)=x^6+x^5+1). Takes a
//  serial bit stream, self-synchronises to the sequence, flags each bit error
//  and keeps a saturating error count. Sits at the far end of a link or loopback
//  under test, fed one bit per din_valid.
// PARAMETERS
//  LOCK_COUNT  12  consecutive correct predictions in VERIFY before LOCKED
//  WINDOW      64  valid bits per loss-of-lock observation window (>=2)
//  UNLOCK_ERRS 8   errors within one window that force ACQUIRE (1..WINDOW)
//  CNT_W       16  width of err_count
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  reset      in   1      synchronous, active-high
//  din        in   1      received serial bit
//  din_valid  in   1      din is sampled only when high
//  clr_cnt    in   1      synchronous clear of err_count
//  locked     out  1      checker is in LOCKED
//  err        out  1      one-cycle pulse: last valid bit mismatched while LOCKED
//  err_count  out  CNT_W  saturating count of LOCKED mismatches
// BEHAVIOUR
//  - Reset: state=ACQUIRE; history h[1:6]=0; fill/run/window counters=0;
//    locked=0, err=0, err_count=0. Reset overrides all other inputs.
//  - History: h[1] newest bit, h[k] is the bit k valid cycles back.
//    Predicted bit p = h[6]^h[5]. Nothing changes on cycles with din_valid=0,
//    except that err is 0 and clr_cnt still acts.
//  - ACQUIRE: each valid bit shifts in: h <= {din, h[1:5]}. After the 6th valid
//    bit, go to VERIFY with run=0.
//  - VERIFY: each valid bit shifts din in and compares it with p.
//    * A match with h!=0 increments run. When run reaches LOCK_COUNT, go to
//      LOCKED and clear the window counters.
//    * A mismatch, or h==0 (the all-zero lockup state), goes to ACQUIRE with
//      fill=0.
//    * No err pulse and no counting in this state.
//  - LOCKED (flywheel): each valid bit shifts p in, not din: h <= {p, h[1:5]}.
//    Each received bit error therefore counts exactly once.
//    * On a mismatch: err=1 on the next cycle, and err_count increments,
//      saturating at 2^CNT_W-1.
//    * Window: win_bits counts valid bits 0..WINDOW-1. win_errs counts
//      mismatches. Both clear when win_bits wraps from WINDOW-1 to 0.
//    * If win_errs, including the current bit, reaches UNLOCK_ERRS: go to
//      ACQUIRE, fill=0, window counters cleared. That bit still pulses err and
//      still counts.
//  - Outputs are registered. locked=1 on the cycle after the transition into
//    LOCKED, and =0 on the cycle after leaving it. err latency is 1 cycle.
//  - clr_cnt with no concurrent error: err_count=0 next cycle. clr_cnt in the
//    same cycle as a counted mismatch: err_count=1. clr_cnt affects nothing else.
//  - Minimum lock time from reset on a clean stream: 6+LOCK_COUNT valid bits.
//  - Stream convention: the bench feeds the generator's newest bit, i.e. the
//    element written by the feedback, once per shift.
// TESTING
//  1 Clean stream from seed 110101, din_valid=1 continuously -> locked rises
//    after 18 valid bits; over the next 252 bits, err never pulses and
//    err_count stays 0.
//  2 Locked; invert one bit -> exactly one err pulse, one cycle after that bit;
//    err_count=1; locked stays 1.
//  3 Locked; invert 8 bits within 64 -> err_count=8; locked falls after the
//    8th error; locked rises again 18 clean bits later.
//  4 All-zero din for 200 bits -> locked never asserts, err never pulses.
//    Alternating 1010... stream -> locked never asserts.
//  5 Clean stream with pseudo-random din_valid gaps (~50% duty) -> same results
//    as 1 and 2, counted in valid bits.
//  6 CNT_W=4 with 20 isolated errors (UNLOCK_ERRS not reached) -> saturates at
//    15. clr_cnt together with an error -> 1. reset while locked -> locked=0,
//    err_count=0 next cycle.

Source files
------------

// File: rtl/prbs6_checker.sv
// PRBS6 (x^6+x^5+1) receive checker: self-synchronises to the incoming bit
// stream, flywheels once locked, flags bit errors and keeps a saturating count.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ACQUIRE | filling the 6-bit history straight from din
//  VERIFY  | history full; counting consecutive correct predictions
//  LOCKED  | flywheel: history advances on predictions, mismatches counted
module prbs6_checker #(
  parameter int LOCK_COUNT  = 12,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int WB_W  = $clog2(WINDOW);
  localparam int WE_W  = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;

  localparam logic [2:0]      FILL_LAST = 3'd5;
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [WB_W-1:0]  BITS_LAST = WB_W'(WINDOW - 1);
  localparam logic [WE_W-1:0]  ERRS_LAST = WE_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        hist_q, hist_d;       // [0] newest bit, [5] six bits back
  logic [2:0]        fill_q, fill_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WB_W-1:0]   win_bits_q, win_bits_d;
  logic [WE_W-1:0]   win_errs_q, win_errs_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic pred;
  logic miss;
  logic count_hit;

  assign pred = hist_q[5] ^ hist_q[4];
  assign miss = din ^ pred;

  // Next-state, history, window and counter update.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    run_d      = run_q;
    win_bits_d = win_bits_q;
    win_errs_d = win_errs_q;
    err_d      = 1'b0;
    count_hit  = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        ACQUIRE: begin
          hist_d = {hist_q[4:0], din};
          if (fill_q == FILL_LAST) begin
            state_d = VERIFY;
            fill_d  = '0;
            run_d   = '0;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
        VERIFY: begin
          hist_d = {hist_q[4:0], din};
          // An all-zero history predicts zeros forever; never trust it.
          if (miss || (hist_q == 6'd0)) begin
            state_d = ACQUIRE;
            fill_d  = '0;
          end else if (run_q == RUN_LAST) begin
            state_d    = LOCKED;
            run_d      = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so one bad bit counts exactly once.
          hist_d    = {hist_q[4:0], pred};
          err_d     = miss;
          count_hit = miss;
          if (miss && (win_errs_q == ERRS_LAST)) begin
            state_d    = ACQUIRE;
            fill_d     = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits_q == BITS_LAST) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + WB_W'(1);
            if (miss) win_errs_d = win_errs_q + WE_W'(1);
          end
        end
        default: begin
          state_d = ACQUIRE;
          fill_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);

    if (clr_cnt) begin
      cnt_d = count_hit ? CNT_W'(1) : '0;
    end else if (count_hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACQUIRE;
      hist_q     <= '0;
      fill_q     <= '0;
      run_q      <= '0;
      win_bits_q <= '0;
      win_errs_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      run_q      <= run_d;
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_prbs6_checker.sv
// Bench for prbs6_checker: a default instance and a CNT_W=4 instance share
// all inputs. Expected err values are queued as each bit is driven and
// compared after the edge that consumes that bit.
module tb_prbs6_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        din_valid;
  logic        clr_cnt;
  logic        locked, err;
  logic [15:0] err_count;
  logic        locked4, err4;
  logic [3:0]  err_count4;

  logic [5:0]  g;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_q[$];

  prbs6_checker dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_count(err_count)
  );

  prbs6_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .clr_cnt(clr_cnt), .locked(locked4), .err(err4), .err_count(err_count4)
  );

  always #5 clk = ~clk;

  // Reference generator: newest bit is the feedback value.
  function automatic logic gen_next();
    logic nb;
    nb = g[5] ^ g[4];
    g  = {g[4:0], nb};
    return nb;
  endfunction

  task automatic send(input logic d, input logic v, input logic e);
    din       = d;
    din_valid = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic lock_clean();
    g = 6'b110101;
    for (int i = 0; i < 18; i++) send(gen_next(), 1'b1, 1'b0);
  endtask

  // Scoreboard: pop the expectation queued before this edge, check after it.
  initial begin
    logic e;
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        #2;
        n_cmp++;
        if (err !== e) begin
          n_bad++;
          $display("FAIL err_pulse: got %0b expected %0b at %0t", err, e, $time);
        end
        n_cmp++;
        if (err4 !== e) begin
          n_bad++;
          $display("FAIL err_pulse_w4: got %0b expected %0b at %0t", err4, e, $time);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: got locked=%0b err=%0b cnt=%0d expected 0/0/0", locked, err, err_count);
    end
    n_cmp++;
    if (locked4 !== 1'b0 || err4 !== 1'b0 || err_count4 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state_w4: got locked=%0b err=%0b cnt=%0d expected 0/0/0", locked4, err4, err_count4);
    end
  endtask

  task automatic test_clean_lock();
    do_reset();
    g = 6'b110101;
    for (int i = 1; i <= 18; i++) begin
      send(gen_next(), 1'b1, 1'b0);
      n_cmp++;
      if (locked !== (i >= 18)) begin
        n_bad++;
        $display("FAIL lock_time: after %0d bits got locked=%0b expected %0b", i, locked, (i >= 18));
      end
    end
    for (int i = 0; i < 252; i++) begin
      send(gen_next(), 1'b1, 1'b0);
      n_cmp++;
      if (locked !== 1'b1) begin
        n_bad++;
        $display("FAIL clean_hold: bit %0d got locked=%0b expected 1", i, locked);
      end
    end
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL clean_count: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_single_error();
    send(~gen_next(), 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) send(gen_next(), 1'b1, 1'b0);
    n_cmp++;
    if (err_count !== 16'd1) begin
      n_bad++;
      $display("FAIL single_count: got %0d expected 1", err_count);
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL single_locked: got %0b expected 1", locked);
    end
  endtask

  task automatic test_unlock_relock();
    do_reset();
    lock_clean();
    for (int j = 1; j <= 8; j++) begin
      send(gen_next(), 1'b1, 1'b0);
      send(~gen_next(), 1'b1, 1'b1);
      n_cmp++;
      if (locked !== (j < 8)) begin
        n_bad++;
        $display("FAIL unlock_edge: after error %0d got locked=%0b expected %0b", j, locked, (j < 8));
      end
    end
    n_cmp++;
    if (err_count !== 16'd8) begin
      n_bad++;
      $display("FAIL unlock_count: got %0d expected 8", err_count);
    end
    for (int i = 1; i <= 18; i++) begin
      send(gen_next(), 1'b1, 1'b0);
      n_cmp++;
      if (locked !== (i >= 18)) begin
        n_bad++;
        $display("FAIL relock_time: after %0d bits got locked=%0b expected %0b", i, locked, (i >= 18));
      end
    end
  endtask

  task automatic test_no_lock_patterns();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      send(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (locked !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_stream: bit %0d got locked=%0b expected 0", i, locked);
      end
    end
    for (int i = 0; i < 200; i++) begin
      send(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (locked !== 1'b0) begin
        n_bad++;
        $display("FAIL alt_stream: bit %0d got locked=%0b expected 0", i, locked);
      end
    end
  endtask

  task automatic test_gapped_valid();
    int   nv;
    int   cyc;
    logic v;
    do_reset();
    g   = 6'b110101;
    nv  = 0;
    cyc = 0;
    while (nv < 270 && cyc < 3000) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        send(gen_next(), 1'b1, 1'b0);
        nv++;
      end else begin
        send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      cyc++;
      n_cmp++;
      if (locked !== (nv >= 18)) begin
        n_bad++;
        $display("FAIL gap_lock: after %0d valid bits got locked=%0b expected %0b", nv, locked, (nv >= 18));
      end
    end
    n_cmp++;
    if (nv != 270) begin
      n_bad++;
      $display("FAIL gap_budget: got %0d valid bits expected 270", nv);
    end
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL gap_clean_count: got %0d expected 0", err_count);
    end
    send(~gen_next(), 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) send(gen_next(), 1'b1, 1'b0);
      else   send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    n_cmp++;
    if (err_count !== 16'd1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_single: got cnt=%0d locked=%0b expected 1/1", err_count, locked);
    end
  endtask

  task automatic test_saturate_clear_reset();
    logic d;
    do_reset();
    lock_clean();
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 9; i++) send(gen_next(), 1'b1, 1'b0);
      send(~gen_next(), 1'b1, 1'b1);
    end
    n_cmp++;
    if (err_count4 !== 4'd15) begin
      n_bad++;
      $display("FAIL saturate_w4: got %0d expected 15", err_count4);
    end
    n_cmp++;
    if (err_count !== 16'd20) begin
      n_bad++;
      $display("FAIL count_20: got %0d expected 20", err_count);
    end
    n_cmp++;
    if (locked !== 1'b1 || locked4 !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_locked: got %0b/%0b expected 1/1", locked, locked4);
    end
    for (int i = 0; i < 9; i++) send(gen_next(), 1'b1, 1'b0);
    clr_cnt = 1'b1;
    send(~gen_next(), 1'b1, 1'b1);
    clr_cnt = 1'b0;
    n_cmp++;
    if (err_count !== 16'd1 || err_count4 !== 4'd1) begin
      n_bad++;
      $display("FAIL clr_with_err: got %0d/%0d expected 1/1", err_count, err_count4);
    end
    for (int i = 0; i < 5; i++) send(gen_next(), 1'b1, 1'b0);
    clr_cnt = 1'b1;
    send(gen_next(), 1'b1, 1'b0);
    clr_cnt = 1'b0;
    n_cmp++;
    if (err_count !== 16'd0 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_plain: got cnt=%0d locked=%0b expected 0/1", err_count, locked);
    end
    send(~gen_next(), 1'b1, 1'b1);
    d         = ~gen_next();
    reset     = 1'b1;
    din       = d;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0 || err_count4 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_locked: got locked=%0b err=%0b cnt=%0d/%0d expected 0/0/0/0",
               locked, err, err_count, err_count4);
    end
    reset     = 1'b0;
    din_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    g         = 6'b110101;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_unlock_relock();
    test_no_lock_patterns();
    test_gapped_valid();
    test_saturate_clear_reset();
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
